// File: rtl/mux_pipe_if.sv
// Handshake bundle for mux_pipe: N producer channels in, one registered consumer port out.
// The master side is the environment (producers plus consumer); the slave side is the mux.
interface mux_pipe_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int SELW     = 2
);
    logic [SELW-1:0]           sel;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH-1:0]          out_data;
    logic [SELW-1:0]           out_chan;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/mux_pipe.sv
// Registered N-channel valid/ready mux, external-select or round-robin; 1-cycle accept-to-valid latency.
// Backpressure: a stalled output holds its word and forces every in_ready low; drain and refill share a cycle.
module mux_pipe #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int MODE     = 0,
    parameter int SELW     = 2
) (
    input  logic         clock,
    input  logic         reset_n,
    mux_pipe_if.slave    bus
);

    logic                load;
    logic                gnt_en;
    logic                gnt_vld;
    logic [SELW-1:0]     gnt;
    logic [WIDTH-1:0]    gnt_dat;
    logic                xfer;

    logic                out_valid_q, out_valid_d;
    logic [WIDTH-1:0]    out_data_q,  out_data_d;
    logic [SELW-1:0]     out_chan_q,  out_chan_d;
    logic [SELW-1:0]     rr_ptr_q,    rr_ptr_d;

    // The output register can take a word when empty or when it is being drained this cycle.
    assign load = !out_valid_q || bus.out_ready;

    always_comb begin
        gnt     = '0;
        gnt_en  = 1'b0;
        gnt_vld = 1'b0;
        if (MODE == 0) begin
            gnt    = bus.sel;
            gnt_en = (int'(bus.sel) < CHANNELS);
            for (int i = 0; i < CHANNELS; i++) begin
                if (gnt_en && (int'(bus.sel) == i)) begin
                    gnt_vld = bus.in_valid[i];
                end
            end
        end else begin
            // Scan in order rr_ptr, rr_ptr+1, ... (mod CHANNELS); first requester wins.
            for (int k = 0; k < CHANNELS; k++) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (!gnt_vld && (i == ((int'(rr_ptr_q) + k) % CHANNELS)) && bus.in_valid[i]) begin
                        gnt_vld = 1'b1;
                        gnt     = SELW'(i);
                    end
                end
            end
            gnt_en = gnt_vld;
        end
    end

    always_comb begin
        gnt_dat = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (gnt == SELW'(i)) begin
                gnt_dat = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // In external-select mode in_ready ignores in_valid so producers see a stable ready.
    always_comb begin
        bus.in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            bus.in_ready[i] = reset_n && load && gnt_en && (gnt == SELW'(i));
        end
    end

    assign xfer = load && gnt_vld;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            out_valid_d = gnt_vld;
            if (gnt_vld) begin
                out_data_d = gnt_dat;
                out_chan_d = gnt;
            end
        end
        if ((MODE == 1) && xfer) begin
            rr_ptr_d = (gnt == SELW'(CHANNELS - 1)) ? '0 : gnt + SELW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;

    // A stalled word must not change or vanish until the consumer takes it.
    a_stall_hold: assert property (@(posedge clock) disable iff (!reset_n)
        (out_valid_q && !bus.out_ready) |=> (out_valid_q && $stable(out_data_q) && $stable(out_chan_q)));

    a_ready_onehot: assert property (@(posedge clock) disable iff (!reset_n)
        $onehot0(bus.in_ready) && (load || (bus.in_ready == '0)));

endmodule

// File: tb/tb_mux_pipe.sv
module tb_mux_pipe;

    logic clock;
    logic reset_n;
    int   tests;
    int   fails;

    mux_pipe_if #(.CHANNELS(4), .WIDTH(8), .SELW(2)) b0 ();
    mux_pipe_if #(.CHANNELS(4), .WIDTH(8), .SELW(2)) b1 ();
    mux_pipe_if #(.CHANNELS(3), .WIDTH(8), .SELW(2)) b2 ();

    mux_pipe #(.CHANNELS(4), .WIDTH(8), .MODE(0), .SELW(2)) u_sel (
        .clock(clock), .reset_n(reset_n), .bus(b0.slave));
    mux_pipe #(.CHANNELS(4), .WIDTH(8), .MODE(1), .SELW(2)) u_rr (
        .clock(clock), .reset_n(reset_n), .bus(b1.slave));
    mux_pipe #(.CHANNELS(3), .WIDTH(8), .MODE(0), .SELW(2)) u_oor (
        .clock(clock), .reset_n(reset_n), .bus(b2.slave));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required finished");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_all;
        b0.in_valid = '0; b0.out_ready = 1'b1; b0.sel = '0; b0.in_data = '0;
        b1.in_valid = '0; b1.out_ready = 1'b1; b1.sel = '0; b1.in_data = '0;
        b2.in_valid = '0; b2.out_ready = 1'b1; b2.sel = '0; b2.in_data = '0;
        tick;
        tick;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        b0.sel = 2'd2; b0.in_data = 32'h00A5_0000; b0.in_valid = 4'b0100; b0.out_ready = 1'b0;
        b1.sel = '0; b1.in_data = '0; b1.in_valid = '0; b1.out_ready = 1'b0;
        b2.sel = '0; b2.in_data = '0; b2.in_valid = '0; b2.out_ready = 1'b0;
        #12;
        tests++; if (b0.out_valid !== 1'b0 || b1.out_valid !== 1'b0 || b2.out_valid !== 1'b0) begin
            fails++; $display("FAIL reset_vld: got %b%b%b want 000", b0.out_valid, b1.out_valid, b2.out_valid); end
        tests++; if (b0.out_data !== 8'h00 || b0.out_chan !== 2'd0) begin
            fails++; $display("FAIL reset_out: got data %h chan %0d want 00/0", b0.out_data, b0.out_chan); end
        tests++; if (b0.in_ready !== 4'b0000) begin
            fails++; $display("FAIL reset_rdy: got %b want 0000", b0.in_ready); end
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        tests++; if (b0.in_ready !== 4'b0100) begin
            fails++; $display("FAIL release_rdy: got %b want 0100", b0.in_ready); end
        tick;
        tests++; if (b0.out_valid !== 1'b1 || b0.out_data !== 8'hA5 || b0.out_chan !== 2'd2) begin
            fails++; $display("FAIL first_accept: got v%b %h ch%0d want v1 a5 ch2", b0.out_valid, b0.out_data, b0.out_chan); end
        // Assert reset while the word is held under backpressure.
        b0.in_valid = '0;
        #2;
        reset_n = 1'b0;
        #1;
        tests++; if (b0.out_valid !== 1'b0 || b0.out_data !== 8'h00 || b0.out_chan !== 2'd0) begin
            fails++; $display("FAIL midreset_out: got v%b %h ch%0d want v0 00 ch0", b0.out_valid, b0.out_data, b0.out_chan); end
        tests++; if (b0.in_ready !== 4'b0000) begin
            fails++; $display("FAIL midreset_rdy: got %b want 0000", b0.in_ready); end
        @(negedge clock);
        reset_n = 1'b1;
        idle_all;
    endtask

    task automatic test_mode0_basic;
        b0.sel = 2'd2; b0.in_data = 32'h00A5_0000; b0.in_valid = 4'b0100; b0.out_ready = 1'b1;
        #1;
        tests++; if (b0.in_ready !== 4'b0100) begin
            fails++; $display("FAIL basic_rdy2: got %b want 0100", b0.in_ready); end
        tick;
        tests++; if (b0.out_valid !== 1'b1 || b0.out_data !== 8'hA5 || b0.out_chan !== 2'd2) begin
            fails++; $display("FAIL basic_a5: got v%b %h ch%0d want v1 a5 ch2", b0.out_valid, b0.out_data, b0.out_chan); end
        b0.sel = 2'd1; b0.in_data = 32'h0000_3C00; b0.in_valid = 4'b0010;
        #1;
        tests++; if (b0.in_ready !== 4'b0010) begin
            fails++; $display("FAIL basic_rdy1: got %b want 0010", b0.in_ready); end
        tick;
        tests++; if (b0.out_valid !== 1'b1 || b0.out_data !== 8'h3C || b0.out_chan !== 2'd1) begin
            fails++; $display("FAIL basic_3c: got v%b %h ch%0d want v1 3c ch1", b0.out_valid, b0.out_data, b0.out_chan); end
        b0.in_valid = '0;
        tick;
        tests++; if (b0.out_valid !== 1'b0 || b0.out_data !== 8'h3C || b0.out_chan !== 2'd1) begin
            fails++; $display("FAIL basic_idle: got v%b %h ch%0d want v0 3c ch1", b0.out_valid, b0.out_data, b0.out_chan); end
        idle_all;
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp [4];
        exp[0] = 8'h01; exp[1] = 8'h23; exp[2] = 8'h45; exp[3] = 8'h67;
        b0.in_data = 32'h6745_2301; b0.in_valid = 4'b1111; b0.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            b0.sel = 2'(3 - k);
            tick;
            tests++; if (b0.out_valid !== 1'b1 || b0.out_data !== exp[3-k] || b0.out_chan !== 2'(3 - k)) begin
                fails++; $display("FAIL b2b_%0d: got v%b %h ch%0d want v1 %h ch%0d", k, b0.out_valid, b0.out_data, b0.out_chan, exp[3-k], 3 - k); end
        end
        idle_all;
    endtask

    task automatic test_backpressure;
        int a5_delivered;
        a5_delivered = 0;
        b0.sel = 2'd2; b0.in_data = 32'h00A5_0000; b0.in_valid = 4'b0100; b0.out_ready = 1'b1;
        tick;
        b0.in_data = 32'h0011_0000; b0.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            tests++; if (b0.in_ready !== 4'b0000) begin
                fails++; $display("FAIL bp_rdy_%0d: got %b want 0000", k, b0.in_ready); end
            tick;
            tests++; if (b0.out_valid !== 1'b1 || b0.out_data !== 8'hA5) begin
                fails++; $display("FAIL bp_hold_%0d: got v%b %h want v1 a5", k, b0.out_valid, b0.out_data); end
        end
        b0.out_ready = 1'b1;
        #1;
        tests++; if (b0.in_ready !== 4'b0100) begin
            fails++; $display("FAIL bp_release_rdy: got %b want 0100", b0.in_ready); end
        if (b0.out_valid && b0.out_data == 8'hA5) a5_delivered++;
        tick;
        tests++; if (b0.out_valid !== 1'b1 || b0.out_data !== 8'h11) begin
            fails++; $display("FAIL bp_next: got v%b %h want v1 11", b0.out_valid, b0.out_data); end
        if (b0.out_valid && b0.out_data == 8'hA5) a5_delivered++;
        b0.in_valid = '0;
        tick;
        tests++; if (b0.out_valid !== 1'b0) begin
            fails++; $display("FAIL bp_drain: got v%b want v0", b0.out_valid); end
        tests++; if (a5_delivered != 1) begin
            fails++; $display("FAIL bp_once: got %0d a5 deliveries want 1", a5_delivered); end
        idle_all;
    endtask

    task automatic test_rr_fairness;
        logic [1:0] exp_ch [6];
        exp_ch[0] = 2'd0; exp_ch[1] = 2'd1; exp_ch[2] = 2'd2;
        exp_ch[3] = 2'd3; exp_ch[4] = 2'd0; exp_ch[5] = 2'd1;
        b1.in_data = 32'h1312_1110; b1.in_valid = 4'b1111; b1.out_ready = 1'b1;
        #1;
        tests++; if (b1.in_ready !== 4'b0001) begin
            fails++; $display("FAIL rr_rdy0: got %b want 0001", b1.in_ready); end
        for (int k = 0; k < 6; k++) begin
            tick;
            tests++; if (b1.out_valid !== 1'b1 || b1.out_chan !== exp_ch[k] || b1.out_data !== (8'h10 + 8'(exp_ch[k]))) begin
                fails++; $display("FAIL rr_seq_%0d: got v%b ch%0d %h want v1 ch%0d %h", k, b1.out_valid, b1.out_chan, b1.out_data, exp_ch[k], 8'h10 + 8'(exp_ch[k])); end
        end
        b1.in_valid = '0;
        tick;
    endtask

    task automatic test_rr_wrap;
        logic [1:0] exp_ch [4];
        exp_ch[0] = 2'd3; exp_ch[1] = 2'd0; exp_ch[2] = 2'd3; exp_ch[3] = 2'd0;
        // Pointer sits at 2 after fairness; a lone ch0 grant moves it to 1.
        b1.in_data = 32'h3332_3130; b1.in_valid = 4'b0001; b1.out_ready = 1'b1;
        tick;
        tests++; if (b1.out_chan !== 2'd0 || b1.out_data !== 8'h30) begin
            fails++; $display("FAIL rr_prime: got ch%0d %h want ch0 30", b1.out_chan, b1.out_data); end
        b1.in_valid = 4'b1001;
        #1;
        tests++; if (b1.in_ready !== 4'b1000) begin
            fails++; $display("FAIL rr_wrap_rdy: got %b want 1000", b1.in_ready); end
        for (int k = 0; k < 4; k++) begin
            tick;
            tests++; if (b1.out_valid !== 1'b1 || b1.out_chan !== exp_ch[k] || b1.out_data !== (8'h30 + 8'(exp_ch[k]))) begin
                fails++; $display("FAIL rr_wrap_%0d: got v%b ch%0d %h want v1 ch%0d %h", k, b1.out_valid, b1.out_chan, b1.out_data, exp_ch[k], 8'h30 + 8'(exp_ch[k])); end
        end
        b1.in_valid = '0;
        tick;
        tick;
        b1.in_valid = 4'b1111;
        tick;
        tests++; if (b1.out_chan !== 2'd1 || b1.out_data !== 8'h31) begin
            fails++; $display("FAIL rr_ptr_hold: got ch%0d %h want ch1 31", b1.out_chan, b1.out_data); end
        idle_all;
    endtask

    task automatic test_out_of_range;
        b2.sel = 2'd1; b2.in_data = 24'h00_7700; b2.in_valid = 3'b010; b2.out_ready = 1'b1;
        tick;
        tests++; if (b2.out_valid !== 1'b1 || b2.out_data !== 8'h77 || b2.out_chan !== 2'd1) begin
            fails++; $display("FAIL oor_load: got v%b %h ch%0d want v1 77 ch1", b2.out_valid, b2.out_data, b2.out_chan); end
        b2.sel = 2'd3; b2.in_data = 24'h5A_6B7C; b2.in_valid = 3'b111;
        #1;
        tests++; if (b2.in_ready !== 3'b000) begin
            fails++; $display("FAIL oor_rdy: got %b want 000", b2.in_ready); end
        tick;
        tests++; if (b2.out_valid !== 1'b0 || b2.out_data !== 8'h77 || b2.out_chan !== 2'd1) begin
            fails++; $display("FAIL oor_drain: got v%b %h ch%0d want v0 77 ch1", b2.out_valid, b2.out_data, b2.out_chan); end
        tick;
        tests++; if (b2.out_valid !== 1'b0 || b2.in_ready !== 3'b000) begin
            fails++; $display("FAIL oor_stay: got v%b rdy %b want v0 000", b2.out_valid, b2.in_ready); end
        b2.sel = 2'd0;
        #1;
        tests++; if (b2.in_ready !== 3'b001) begin
            fails++; $display("FAIL oor_back_rdy: got %b want 001", b2.in_ready); end
        tick;
        tests++; if (b2.out_valid !== 1'b1 || b2.out_data !== 8'h7C || b2.out_chan !== 2'd0) begin
            fails++; $display("FAIL oor_back: got v%b %h ch%0d want v1 7c ch0", b2.out_valid, b2.out_data, b2.out_chan); end
        idle_all;
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        reset_n = 1'b0;
        test_reset;
        test_mode0_basic;
        test_back_to_back;
        test_backpressure;
        test_rr_fairness;
        test_rr_wrap;
        test_out_of_range;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
